// File: rtl/tb_policer.sv
// Per-packet token-bucket policer: each passed packet costs one token at its head word,
// the stream is forwarded with a fixed one-cycle latency, and dropped packets are blanked.
module tb_policer #(
  parameter int unsigned TOKEN_W = 16,
  parameter logic [7:0]  LMID    = 8'd13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] in_tb_data,
  input  logic         in_tb_data_wr,
  input  logic         in_tb_data_valid,
  input  logic         in_tb_data_valid_wr,
  input  logic [31:0]  in_token_bucket_para,
  input  logic         in_beacon_update_master,
  output logic [133:0] out_tb_data,
  output logic         out_tb_data_wr,
  output logic         out_tb_data_valid,
  output logic         out_tb_data_valid_wr,
  output logic [31:0]  out_pass_cnt,
  output logic [31:0]  out_drop_cnt
);

  if ($bits(LMID) != 8) begin : g_lmid_width
    $error("LMID must be 8 bits wide");
  end

  typedef enum logic [1:0] {IDLE_S, PASS_S, DROP_S} state_e;

  state_e               state_q, state_d;
  logic [TOKEN_W-1:0]   tokens_q, tokens_d;
  logic [15:0]          refill_q, refill_d;
  logic                 bcn_q;
  logic                 last_pass_q;
  logic [133:0]         out_data_q;
  logic                 out_wr_q, out_vld_q, out_vwr_q;
  logic [31:0]          pass_cnt_q, drop_cnt_q;

  logic [TOKEN_W-1:0]   cap, base;
  logic [15:0]          interval;
  logic                 is_head, is_tail, pol_dis, tick, bcn_edge, pass_ok;
  logic                 fwd, dec_pass, dec_drop, charge, vwr_fwd;

  assign cap      = TOKEN_W'(in_token_bucket_para[31:16]);
  assign interval = in_token_bucket_para[15:0];
  assign is_head  = in_tb_data_wr && (in_tb_data[133:132] == 2'b01);
  assign is_tail  = in_tb_data_wr && (in_tb_data[133:132] == 2'b10);
  assign pol_dis  = (interval == 16'd0);
  // >= rather than == so a shortened interval cannot strand the counter above it
  assign tick     = !pol_dis && (refill_q >= interval - 16'd1);
  assign bcn_edge = in_beacon_update_master ^ bcn_q;
  assign pass_ok  = pol_dis || (tokens_q != '0);
  assign charge   = dec_pass && !pol_dis;
  assign base     = (tokens_q > cap) ? cap : tokens_q;
  assign vwr_fwd  = in_tb_data_valid_wr && last_pass_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE_S;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_head)      state_d = pass_ok ? PASS_S : DROP_S;
    else if (is_tail) state_d = IDLE_S;
  end

  always_comb begin
    fwd      = 1'b0;
    dec_pass = 1'b0;
    dec_drop = 1'b0;
    if (is_head) begin
      dec_pass = pass_ok;
      dec_drop = !pass_ok;
      fwd      = pass_ok;
    end else if (in_tb_data_wr && state_q == PASS_S) begin
      fwd = 1'b1;
    end
  end

  // Beacon reload wins over refill and charge; a coincident refill and charge cancel.
  always_comb begin
    if (bcn_edge)              tokens_d = cap;
    else if (tick && charge)   tokens_d = base;
    else if (tick)             tokens_d = (base < cap) ? base + TOKEN_W'(1) : base;
    else if (charge && base != '0) tokens_d = base - TOKEN_W'(1);
    else                       tokens_d = base;
  end

  always_comb begin
    if (bcn_edge || pol_dis || tick) refill_d = '0;
    else                             refill_d = refill_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens_q    <= '0;
      refill_q    <= '0;
      bcn_q       <= 1'b0;
      last_pass_q <= 1'b0;
      pass_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      tokens_q <= tokens_d;
      refill_q <= refill_d;
      bcn_q    <= in_beacon_update_master;
      if (dec_pass)      last_pass_q <= 1'b1;
      else if (dec_drop) last_pass_q <= 1'b0;
      if (dec_pass) pass_cnt_q <= pass_cnt_q + 32'd1;
      if (dec_drop) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_wr_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_vwr_q  <= 1'b0;
    end else begin
      out_data_q <= fwd ? in_tb_data : '0;
      out_wr_q   <= fwd;
      out_vwr_q  <= vwr_fwd;
      out_vld_q  <= vwr_fwd && in_tb_data_valid;
    end
  end

  assign out_tb_data          = out_data_q;
  assign out_tb_data_wr       = out_wr_q;
  assign out_tb_data_valid    = out_vld_q;
  assign out_tb_data_valid_wr = out_vwr_q;
  assign out_pass_cnt         = pass_cnt_q;
  assign out_drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_tb_policer.sv
// Directed bench for tb_policer: table of per-cycle vectors plus hand-built
// sequences for refill saturation, beacon reload and mid-packet reset.
module tb_tb_policer;

  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] MD = 2'b11;
  localparam logic [1:0] TL = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [133:0] in_tb_data = '0;
  logic         in_tb_data_wr = 1'b0;
  logic         in_tb_data_valid = 1'b0;
  logic         in_tb_data_valid_wr = 1'b0;
  logic [31:0]  in_token_bucket_para = '0;
  logic         in_beacon = 1'b0;
  logic [133:0] out_tb_data;
  logic         out_tb_data_wr, out_tb_data_valid, out_tb_data_valid_wr;
  logic [31:0]  out_pass_cnt, out_drop_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int seq = 0;

  typedef struct {
    logic [1:0] typ;
    logic wr, vld, vwr, tgl, efwd, evld, evwr;
  } vec_t;

  vec_t tbl [24];

  tb_policer #(.TOKEN_W(16), .LMID(8'd13)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .in_tb_data              (in_tb_data),
    .in_tb_data_wr           (in_tb_data_wr),
    .in_tb_data_valid        (in_tb_data_valid),
    .in_tb_data_valid_wr     (in_tb_data_valid_wr),
    .in_token_bucket_para    (in_token_bucket_para),
    .in_beacon_update_master (in_beacon),
    .out_tb_data             (out_tb_data),
    .out_tb_data_wr          (out_tb_data_wr),
    .out_tb_data_valid       (out_tb_data_valid),
    .out_tb_data_valid_wr    (out_tb_data_valid_wr),
    .out_pass_cnt            (out_pass_cnt),
    .out_drop_cnt            (out_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int unsigned ep, input int unsigned ed);
    chk({name, "_pass"}, 256'(out_pass_cnt), 256'(ep));
    chk({name, "_drop"}, 256'(out_drop_cnt), 256'(ed));
  endtask

  // Drive one cycle of input, then compare the registered outputs one cycle later.
  task automatic step(input logic [1:0] typ, input logic wr, input logic vld, input logic vwr,
                      input logic tgl, input logic efwd, input logic evld, input logic evwr,
                      input string name);
    logic [133:0] d;
    logic [133:0] ed;
    seq++;
    d = {typ, {4{32'h1000_0000 + 32'(seq)}}, 4'h5};
    ed = efwd ? d : '0;
    in_tb_data          = d;
    in_tb_data_wr       = wr;
    in_tb_data_valid    = vld;
    in_tb_data_valid_wr = vwr;
    if (tgl) in_beacon = ~in_beacon;
    @(posedge clk);
    #1;
    chk(name, 256'({out_tb_data, out_tb_data_wr, out_tb_data_valid, out_tb_data_valid_wr}),
        256'({ed, efwd, evld, evwr}));
  endtask

  task automatic idle(input string name);
    step(NO, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic do_reset(input logic bcn_lvl);
    rst_n               = 1'b0;
    in_tb_data          = '0;
    in_tb_data_wr       = 1'b0;
    in_tb_data_valid    = 1'b0;
    in_tb_data_valid_wr = 1'b0;
    in_beacon           = bcn_lvl;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", 256'({out_tb_data, out_tb_data_wr, out_tb_data_valid, out_tb_data_valid_wr}), '0);
    chk_cnt("rst_cnt", 0, 0);
    chk("rst_tokens", 256'(dut.tokens_q), '0);
    chk("rst_refill", 256'(dut.refill_q), '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{NO, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{HD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{TL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{NO, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{HD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{TL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{HD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{TL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{NO, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{NO, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{HD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{TL, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{HD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{HD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{TL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{NO, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Policing disabled: every packet passes, nothing charged.
    in_token_bucket_para = 32'h0002_0000;
    do_reset(1'b0);
    for (int p = 0; p < 3; p++) begin
      step(HD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "dis_head");
      step(MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "dis_mid");
      step(MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "dis_mid");
      step(TL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "dis_tail");
    end
    chk_cnt("dis_cnt", 3, 0);
    chk("dis_tokens", 256'(dut.tokens_q), '0);
    chk("dis_refill", 256'(dut.refill_q), '0);

    // Cap 2, long interval: beacon fill, pass/drop, valid gating, missing tail.
    in_token_bucket_para = 32'h0002_0064;
    do_reset(1'b0);
    for (int i = 0; i < 24; i++)
      step(tbl[i].typ, tbl[i].wr, tbl[i].vld, tbl[i].vwr, tbl[i].tgl,
           tbl[i].efwd, tbl[i].evld, tbl[i].evwr, $sformatf("tbl%0d", i));
    chk_cnt("tbl_cnt", 4, 2);

    // Refill saturation from empty, then beacon coinciding with a refill tick.
    in_token_bucket_para = 32'h0003_000A;
    do_reset(1'b0);
    repeat (100) idle("sat_idle");
    chk("sat_tokens", 256'(dut.tokens_q), 256'(3));
    for (int p = 0; p < 4; p++) begin
      step(HD, 1'b1, 1'b0, 1'b0, 1'b0, (p < 3), 1'b0, 1'b0, "sat_head");
      step(TL, 1'b1, 1'b0, 1'b0, 1'b0, (p < 3), 1'b0, 1'b0, "sat_tail");
    end
    chk_cnt("sat_cnt", 3, 1);
    chk("sat_empty", 256'(dut.tokens_q), '0);
    repeat (2) idle("tick_idle");
    chk("tick_tokens", 256'(dut.tokens_q), 256'(1));
    in_token_bucket_para = 32'h0005_000A;
    repeat (9) idle("pre_bcn_idle");
    chk("pre_bcn_tokens", 256'(dut.tokens_q), 256'(1));
    step(NO, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "bcn_tick");
    chk("bcn_tick_tokens", 256'(dut.tokens_q), 256'(5));
    chk("bcn_tick_refill", 256'(dut.refill_q), '0);

    // Asynchronous reset in the middle of a passed packet.
    in_token_bucket_para = 32'h0002_0000;
    do_reset(1'b0);
    step(HD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mrst_head");
    in_tb_data    = {MD, 132'h1234};
    in_tb_data_wr = 1'b1;
    rst_n         = 1'b0;
    #1;
    chk("mrst_out", 256'({out_tb_data, out_tb_data_wr, out_tb_data_valid, out_tb_data_valid_wr}), '0);
    chk_cnt("mrst_cnt", 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(MD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mrst_mid");
    step(TL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mrst_tail");
    step(NO, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mrst_vwr");
    chk_cnt("mrst_after", 0, 0);

    // Beacon held high through reset counts as an edge on release.
    in_token_bucket_para = 32'h0004_0064;
    do_reset(1'b1);
    idle("rel_bcn_idle");
    chk("rel_bcn_tokens", 256'(dut.tokens_q), 256'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tb_policer.md
TB_POLICER -- requirements
Module: tb_policer

Interface
REQ-001 Parameter: TOKEN_W, default 16, width of token counter and bucket cap.
REQ-002 Parameter: LMID, default 8'd13, module ID for local-management addressing; no datapath effect.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_tb_data  input  134  packet word; [133:132] 01=head, 11=middle, 10=tail.
REQ-006 in_tb_data_wr  input  1  in_tb_data write strobe.
REQ-007 in_tb_data_valid  input  1  per-packet valid flag.
REQ-008 in_tb_data_valid_wr  input  1  in_tb_data_valid write strobe, one pulse per packet, at or after tail.
REQ-009 in_token_bucket_para  input  32  [31:16] bucket cap (tokens), [15:0] refill interval (cycles).
REQ-010 in_beacon_update_master  input  1  toggles on each beacon update; any edge reloads bucket.
REQ-011 out_tb_data, out_tb_data_wr, out_tb_data_valid, out_tb_data_valid_wr  output  134/1/1/1  policed stream, registered.
REQ-012 out_pass_cnt  output  32  packets passed, wraps at 2^32.
REQ-013 out_drop_cnt  output  32  packets dropped, wraps at 2^32.

Function
REQ-014 Policing is per packet: each passed packet costs exactly one token, charged in its head cycle.
REQ-015 Latency: every forwarded word/strobe appears exactly 1 cycle after input; no bubbles are inserted.
REQ-016 States: IDLE_S (between packets), PASS_S (forwarding), DROP_S (discarding).
REQ-017 IDLE_S + head word with wr=1: pass if tokens>=1 or interval==0 -> PASS_S; otherwise drop -> DROP_S.
REQ-018 PASS_S: forward every word with wr=1; tail word -> IDLE_S.
REQ-019 DROP_S: out_tb_data_wr=0 and out_tb_data=0; tail word -> IDLE_S.
REQ-020 Head word in PASS_S or DROP_S (missing tail): treat as new head; apply REQ-017 immediately.
REQ-021 Non-head word with wr=1 in IDLE_S: discard; not counted.
REQ-022 Valid strobe forwarded only when the most recent head decision was pass; otherwise out_tb_data_valid_wr=0.
REQ-023 Refill: counter increments each cycle; when it reaches interval-1, it clears and tokens increment by 1, saturating at cap.
REQ-024 interval==0: policing disabled; all packets pass; no token charged; refill counter held at 0.
REQ-025 Same-cycle refill and charge: net token change 0.
REQ-026 Cap lowered below current tokens: tokens clamp to cap on the next cycle.
REQ-027 Edge on in_beacon_update_master (detected vs 1-cycle-delayed copy): next cycle tokens=cap and refill counter=0.
REQ-028 Beacon reload overrides refill and charge in that cycle; a head decided in that cycle uses the pre-reload token value.
REQ-029 Counters: out_pass_cnt increments on each pass decision, out_drop_cnt on each drop decision; 32-bit wrap, no saturation.
REQ-030 Token arithmetic is TOKEN_W wide unsigned; tokens never underflow.

Reset
REQ-031 While rst_n=0, all of the following hold: every output = 0, state = IDLE_S, tokens = 0, refill counter = 0, delayed beacon bit = 0.
REQ-032 Reset mid-packet: the packet is truncated at the output; the remainder after release is handled by REQ-021.
REQ-033 First edge after release: in_beacon_update_master=1 at release counts as an edge and reloads the bucket.

Verification
REQ-034 Set para=0x0002_0000 and send 3 packets of 4 words -> all forwarded 1 cycle late; pass_cnt=3, drop_cnt=0.
REQ-035 Set para=0x0002_0064, toggle beacon, then send 3 back-to-back packets -> first 2 pass, third dropped; out_tb_data_wr=0 for all 4 of its words; drop_cnt=1.
REQ-036 Set cap=3, interval=10, start from empty bucket, idle 100 cycles -> tokens=3 (saturated); 4 packets -> 3 pass, 1 drop.
REQ-037 Drop a packet whose tail is followed by a valid_wr pulse -> no out_tb_data_valid_wr pulse; the next passed packet's valid_wr is forwarded.
REQ-038 Assert rst_n=0 during the middle word of a passed packet -> outputs 0 in the same cycle; after release, trailing words are ignored and counters are 0.
REQ-039 Toggle beacon in the same cycle as a refill tick with tokens=1 and cap=5 -> tokens=5 next cycle.
